// File: rtl/ram_bist_pkg.sv
// Shared constants, FSM state type and march pattern for the RAM BIST controller.
package ram_bist_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 3;
    localparam int unsigned ERR_W  = 7;

    // Two passes over every word is the most mismatches a single run can see.
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(2 * DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StWr0,
        StRd0,
        StWr1,
        StRd1,
        StFlush,
        StDone
    } bist_state_t;

    function automatic logic [DATA_W-1:0] bist_pattern(input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] seed,
                                                       input logic              inv);
        logic [DATA_W-1:0] p;
        p = addr[DATA_W-1:0] ^ seed;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-compare pipeline: one registered read tag per issued read, compared against mem_q
// one cycle later; saturating mismatch count and first-failure capture.
module ram_bist_checker
    import ram_bist_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              issue_pass,
    input  logic [DATA_W-1:0] issue_expected,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_pass,
    output logic              clean_next
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pass_q;
    logic [DATA_W-1:0] exp_q;

    logic              mismatch;
    logic [ERR_W-1:0]  err_count_d;
    logic [ADDR_W-1:0] first_err_addr_d;
    logic              first_err_pass_d;

    always_comb begin
        mismatch         = valid_q && (mem_q != exp_q);
        err_count_d      = err_count;
        first_err_addr_d = first_err_addr;
        first_err_pass_d = first_err_pass;
        if (mismatch) begin
            if (err_count != ERR_MAX) begin
                err_count_d = err_count + ERR_W'(1);
            end
            if (err_count == '0) begin
                first_err_addr_d = addr_q;
                first_err_pass_d = pass_q;
            end
        end
        // Lets the top register pass in the same edge that lands the final compare.
        clean_next = (err_count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q        <= 1'b0;
            addr_q         <= '0;
            pass_q         <= 1'b0;
            exp_q          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_pass <= 1'b0;
        end else begin
            valid_q        <= issue;
            addr_q         <= issue_addr;
            pass_q         <= issue_pass;
            exp_q          <= issue_expected;
            err_count      <= err_count_d;
            first_err_addr <= first_err_addr_d;
            first_err_pass <= first_err_pass_d;
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST master for the lab2 32x3 RAM: write P, read P, write ~P, read ~P, then report.
// Every output is a flop; RAM-port values are computed from the next state.
module ram_bist_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_enable,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [6:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_pass
);

    import ram_bist_pkg::bist_state_t;
    import ram_bist_pkg::bist_pattern;
    import ram_bist_pkg::StIdle;
    import ram_bist_pkg::StWr0;
    import ram_bist_pkg::StRd0;
    import ram_bist_pkg::StWr1;
    import ram_bist_pkg::StRd1;
    import ram_bist_pkg::StFlush;
    import ram_bist_pkg::StDone;

    bist_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              start_ok;
    logic              last_addr;
    logic              wren_d;
    logic [DATA_W-1:0] data_d;
    logic              busy_d;
    logic              done_d;
    logic              clean_next;
    logic              issue;
    logic              issue_pass;

    assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));
    assign mem_addr  = addr_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        seed_d   = seed_q;
        start_ok = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_ok = 1'b1;
                    seed_d   = seed;
                    addr_d   = '0;
                    state_d  = StWr0;
                end
            end
            StWr0: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) state_d = StRd0;
            end
            StRd0: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) state_d = StWr1;
            end
            StWr1: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) state_d = StRd1;
            end
            StRd1: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) state_d = StFlush;
            end
            StFlush: state_d = StDone;
            default: state_d = StIdle;
        endcase

        wren_d = (state_d == StWr0) || (state_d == StWr1);
        data_d = wren_d ? bist_pattern(addr_d, seed_d, state_d == StWr1) : '0;
        busy_d = (state_d != StIdle) && (state_d != StDone);
        done_d = (state_d == StDone);
    end

    // The read tag is taken from the address currently on the port.
    assign issue      = (state_q == StRd0) || (state_q == StRd1);
    assign issue_pass = (state_q == StRd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            seed_q     <= '0;
            mem_data   <= '0;
            mem_wren   <= 1'b0;
            mem_enable <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            seed_q     <= seed_d;
            mem_data   <= data_d;
            mem_wren   <= wren_d;
            mem_enable <= !wren_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= done_d && clean_next;
        end
    end

    ram_bist_checker u_checker (
        .clk            (clk),
        .clear          (reset || start_ok),
        .issue          (issue),
        .issue_addr     (addr_q),
        .issue_pass     (issue_pass),
        .issue_expected (bist_pattern(addr_q, seed_q, issue_pass)),
        .mem_q          (mem_q),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_pass (first_err_pass),
        .clean_next     (clean_next)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench: fault-injecting RAM model plus a loop-based reference for the march.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] seed;
    logic [4:0] mem_addr;
    logic [2:0] mem_data;
    logic       mem_wren;
    logic       mem_enable;
    logic [2:0] mem_q;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [4:0] first_err_addr;
    logic       first_err_pass;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .seed           (seed),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_wren       (mem_wren),
        .mem_enable     (mem_enable),
        .mem_q          (mem_q),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_pass (first_err_pass)
    );

    // RAM with per-word read faults: stuck-at-0 (keep), stuck-at-1 (set), inversion (flip).
    logic [2:0] ram    [32];
    logic [2:0] keep_m [32];
    logic [2:0] set_m  [32];
    logic [2:0] flip_m [32];
    int wr_count   = 0;
    int proto_bad  = 0;

    always @(posedge clk) begin
        mem_q <= ((ram[mem_addr] & keep_m[mem_addr]) | set_m[mem_addr]) ^ flip_m[mem_addr];
        if (mem_wren && !mem_enable) begin
            ram[mem_addr] <= mem_data;
            wr_count      <= wr_count + 1;
        end
        if (mem_wren && mem_enable) proto_bad <= proto_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < 32; a++) begin
            keep_m[a] = 3'b111;
            set_m[a]  = 3'b000;
            flip_m[a] = 3'b000;
        end
    endtask

    // Expected results straight from the march rules: two passes, P then ~P, every word.
    task automatic ref_eval(input logic [2:0] s, output int ec, output int fa, output int fp);
        logic [2:0] w;
        logic [2:0] got;
        ec = 0;
        fa = 0;
        fp = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 32; a++) begin
                w = 3'(a % 8) ^ s;
                if (p == 1) w = ~w;
                got = ((w & keep_m[a]) | set_m[a]) ^ flip_m[a];
                if (got != w) begin
                    if (ec == 0) begin
                        fa = a;
                        fp = p;
                    end
                    ec++;
                end
            end
        end
        if (ec > 64) ec = 64;
    endtask

    task automatic run(input logic [2:0] s, input int pulse_c, input int reset_c,
                       input string tag);
        int ec, fa, fp;
        int w0;
        int bad;
        logic       exp_wren;
        logic [4:0] exp_addr;
        logic [2:0] exp_data;
        ref_eval(s, ec, fa, fp);
        bad = 0;
        @(negedge clk);
        w0    = wr_count;
        start = 1'b1;
        seed  = s;
        @(posedge clk);
        for (int c = 1; c <= 131; c++) begin
            @(negedge clk);
            start = (c == pulse_c);
            if (c == 1) begin
                check({tag, "_clr_done"}, done, 0);
                check({tag, "_clr_err"}, err_count, 0);
                check({tag, "_clr_pass"}, pass, 0);
            end
            exp_wren = (c <= 32) || (c >= 65 && c <= 96);
            exp_addr = (c <= 128) ? 5'((c - 1) % 32) : 5'd0;
            exp_data = 3'(((c - 1) % 32) % 8) ^ s;
            if (c >= 65) exp_data = ~exp_data;
            if (busy !== (c <= 129)) bad++;
            if (done !== (c >= 130)) bad++;
            if (mem_wren !== exp_wren) bad++;
            if (mem_addr !== exp_addr) bad++;
            if (exp_wren && (mem_enable !== 1'b0 || mem_data !== exp_data)) bad++;
            if (c >= 130 && mem_enable !== 1'b1) bad++;
            if (c == reset_c) begin
                check({tag, "_seq_before_reset"}, bad, 0);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check({tag, "_rst_wren"}, mem_wren, 0);
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_done"}, done, 0);
                check({tag, "_rst_err"}, err_count, 0);
                w0  = wr_count;
                bad = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (busy !== 1'b0 || mem_wren !== 1'b0 || mem_addr !== 5'd0) bad++;
                end
                check({tag, "_idle_after_reset"}, bad, 0);
                check({tag, "_no_writes_after_reset"}, wr_count - w0, 0);
                return;
            end
        end
        check({tag, "_sequence"}, bad, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, (ec == 0));
        check({tag, "_err_count"}, err_count, ec);
        check({tag, "_first_addr"}, first_err_addr, fa);
        check({tag, "_first_pass"}, first_err_pass, fp);
        check({tag, "_writes"}, wr_count - w0, 64);
        check({tag, "_proto"}, proto_bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        seed  = 3'b000;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_wren", mem_wren, 0);
        check("rst_enable", mem_enable, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_faddr", first_err_addr, 0);
        check("rst_fpass", first_err_pass, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_holds", busy, 0);

        run(3'b101, 0, 0, "clean");
        check("clean_err_const", err_count, 0);
        check("clean_pass_const", pass, 1);

        keep_m[5] = 3'b110;
        run(3'b000, 0, 0, "stuck5");
        check("stuck5_err_const", err_count, 1);
        check("stuck5_addr_const", first_err_addr, 5);
        check("stuck5_pass_const", first_err_pass, 0);

        clear_faults();
        for (int a = 0; a < 32; a++) keep_m[a] = 3'b000;
        run(3'b000, 0, 0, "allzero");
        check("allzero_err_const", err_count, 56);
        check("allzero_addr_const", first_err_addr, 1);

        // Mid-run start in RD0 must be ignored; the following run re-launches from DONE.
        run(3'b110, 40, 0, "midstart");
        clear_faults();
        run(3'b011, 0, 0, "restart");

        run(3'b011, 0, 74, "reset_wr1");

        for (int a = 0; a < 32; a++) flip_m[a] = 3'b111;
        run(3'($urandom_range(0, 7)), 0, 0, "saturate");
        check("saturate_const", err_count, 64);

        for (int r = 0; r < 4; r++) begin
            clear_faults();
            for (int a = 0; a < 32; a++) begin
                if ($urandom_range(0, 9) == 0) keep_m[a] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) set_m[a]  = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) flip_m[a] = 3'($urandom_range(0, 7));
            end
            run(3'($urandom_range(0, 7)), 0, 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
